// File: rtl/nfc_cmd_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nfc_cmd_sched_if: requester, NFC and completion signals of the    |
// | NFC command scheduler.                Revision: 1.0               |
// +--------------------------------------------------------------------+
interface nfc_cmd_sched_if #(
  parameter int CMD_W = 33
);
  logic             req0_valid;
  logic             req0_ready;
  logic [CMD_W-1:0] req0_cmd;
  logic             req1_valid;
  logic             req1_ready;
  logic [CMD_W-1:0] req1_cmd;
  logic             nfc_start;
  logic [CMD_W-1:0] nfc_cmd;
  logic             nfc_done;
  logic             cpl_valid;
  logic             cpl_id;
  logic [CMD_W-1:0] cpl_cmd;
  logic             busy;

  // Requesters and NFC side
  modport master (
    output req0_valid, req0_cmd, req1_valid, req1_cmd, nfc_done,
    input  req0_ready, req1_ready, nfc_start, nfc_cmd,
           cpl_valid, cpl_id, cpl_cmd, busy
  );

  // Scheduler side
  modport slave (
    input  req0_valid, req0_cmd, req1_valid, req1_cmd, nfc_done,
    output req0_ready, req1_ready, nfc_start, nfc_cmd,
           cpl_valid, cpl_id, cpl_cmd, busy
  );
endinterface
`default_nettype wire

// File: rtl/nfc_cmd_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | nfc_cmd_sched: two per-requester FIFOs, round-robin issue to the  |
// | NFC, completion echo. Option macro: NFC_SCHED_RDPRIO_EN (reads    |
// | first).                               Revision: 1.0               |
// +--------------------------------------------------------------------+
module nfc_cmd_sched #(
  parameter int CMD_W      = 33,
  parameter int FIFO_DEPTH = 4
) (
  input wire             clk,
  input wire             rst,
  nfc_cmd_sched_if.slave bus
);
  localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int c_rw_bit = 32;
  localparam logic [c_ptr_w:0] c_depth = (c_ptr_w+1)'(FIFO_DEPTH);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;
  localparam logic [1:0] c_st_cpl   = 2'd3;

  logic [CMD_W-1:0] r_mem   [2][FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wptr  [2];
  logic [c_ptr_w-1:0] r_rptr  [2];
  logic [c_ptr_w:0]   r_count [2];

  logic [CMD_W-1:0] w_in_cmd [2];
  logic [CMD_W-1:0] w_head   [2];
  logic [1:0]       w_valid;
  logic [1:0]       w_ne;
  logic [1:0]       w_full;
  logic [1:0]       w_push;
  logic [1:0]       w_pop;
  logic [1:0]       w_elig;
`ifdef NFC_SCHED_RDPRIO_EN
  logic [1:0]       w_rd;
`endif
  logic             w_grant;
  logic             w_gnt_id;
  logic [CMD_W-1:0] w_gnt_cmd;

  logic [1:0]       r_state;
  logic             r_rr_last;
  logic [CMD_W-1:0] r_cur_cmd;
  logic             r_cur_id;
  logic [CMD_W-1:0] r_nfc_cmd;

  always_comb begin
    w_valid     = {bus.req1_valid, bus.req0_valid};
    w_in_cmd[0] = bus.req0_cmd;
    w_in_cmd[1] = bus.req1_cmd;
    for (int i = 0; i < 2; i++) begin
      w_ne[i]   = (r_count[i] != '0);
      w_full[i] = (r_count[i] == c_depth);
      w_head[i] = r_mem[i][r_rptr[i]];
      w_push[i] = w_valid[i] & ~w_full[i];
    end
  end

  always_comb begin
`ifdef NFC_SCHED_RDPRIO_EN
    // Read heads shadow write heads; round-robin still decides among reads
    w_rd   = {w_ne[1] & w_head[1][c_rw_bit], w_ne[0] & w_head[0][c_rw_bit]};
    w_elig = (w_rd != 2'b00) ? w_rd : w_ne;
`else
    w_elig = w_ne;
`endif
    if (w_elig == 2'b11) begin
      w_gnt_id = ~r_rr_last;
    end else begin
      w_gnt_id = w_elig[1];
    end
    w_grant   = (r_state == c_st_idle) && (w_elig != 2'b00);
    w_gnt_cmd = w_head[w_gnt_id];
    w_pop     = 2'b00;
    if (w_grant) begin
      w_pop[w_gnt_id] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_wptr[i]  <= '0;
        r_rptr[i]  <= '0;
        r_count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_push[i]) begin
          r_wptr[i] <= r_wptr[i] + 1'b1;
        end
        if (w_pop[i]) begin
          r_rptr[i] <= r_rptr[i] + 1'b1;
        end
        r_count[i] <= r_count[i] + (c_ptr_w+1)'(w_push[i]) - (c_ptr_w+1)'(w_pop[i]);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (w_push[i]) begin
        r_mem[i][r_wptr[i]] <= w_in_cmd[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= c_st_idle;
      r_rr_last <= 1'b1;
      r_cur_cmd <= '0;
      r_cur_id  <= 1'b0;
      r_nfc_cmd <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_grant) begin
            r_cur_cmd <= w_gnt_cmd;
            r_cur_id  <= w_gnt_id;
            r_rr_last <= w_gnt_id;
            // Zero-length commands complete without ever reaching the NFC
            if (w_gnt_cmd[6:0] == 7'd0) begin
              r_state <= c_st_cpl;
            end else begin
              r_state   <= c_st_issue;
              r_nfc_cmd <= w_gnt_cmd;
            end
          end
        end
        c_st_issue: r_state <= c_st_wait;
        c_st_wait: begin
          if (bus.nfc_done) begin
            r_state <= c_st_cpl;
          end
        end
        c_st_cpl: r_state <= c_st_idle;
        default:  r_state <= c_st_idle;
      endcase
    end
  end

  assign bus.req0_ready = ~w_full[0];
  assign bus.req1_ready = ~w_full[1];
  assign bus.nfc_start  = (r_state == c_st_issue);
  assign bus.nfc_cmd    = r_nfc_cmd;
  assign bus.cpl_valid  = (r_state == c_st_cpl);
  assign bus.cpl_id     = r_cur_id;
  assign bus.cpl_cmd    = r_cur_cmd;
  assign bus.busy       = (r_state != c_st_idle) || (w_ne != 2'b00);
endmodule
`default_nettype wire

// File: tb/tb_nfc_cmd_sched.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_nfc_cmd_sched: scoreboard bench with a small NFC responder.    |
// |                                       Revision: 1.0               |
// +--------------------------------------------------------------------+
module tb_nfc_cmd_sched;
  localparam int CMD_W      = 33;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nfc_cmd_sched_if #(.CMD_W(CMD_W)) bus ();

  nfc_cmd_sched #(.CMD_W(CMD_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic             id;
    logic [CMD_W-1:0] cmd;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic stall = 1'b0;
  logic spur  = 1'b0;
  int   lat   = 1;
  int   idle_req = 0;
  int   idle_ack = 0;
  logic outstanding = 1'b0;
  logic drove_done  = 1'b0;
  logic inflight    = 1'b0;
  int   wcnt = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CMD_W-1:0] mk(input logic rw, input logic [17:0] fa,
                                          input logic [6:0] ma, input logic [6:0] len);
    return {rw, fa, ma, len};
  endfunction

  // Scoreboard monitor followed by the NFC responder (done after lat WAIT cycles)
  always @(negedge clk) begin : mon
    logic d_prev;
    exp_t e;
    d_prev       = drove_done;
    drove_done   = 1'b0;
    bus.nfc_done = 1'b0;
    if (rst) begin
      outstanding = 1'b0;
      inflight    = 1'b0;
      exp_q.delete();
    end else begin
      if (bus.nfc_start) begin
        if (exp_q.size() == 0) begin
          check_eq("start_unexpected", 1, 0);
        end else begin
          check_eq("start_cmd", bus.nfc_cmd, exp_q[0].cmd);
          check_eq("start_overlap", inflight, 0);
        end
        inflight = 1'b1;
      end
      if (bus.cpl_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("cpl_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check_eq("cpl_id", bus.cpl_id, e.id);
          check_eq("cpl_cmd", bus.cpl_cmd, e.cmd);
          if (e.cmd[6:0] != 7'd0) check_eq("cpl_after_done", d_prev, 1);
        end
        inflight = 1'b0;
      end else if (d_prev) begin
        check_eq("cpl_missing", 0, 1);
      end
      if (bus.nfc_start) begin
        outstanding = 1'b1;
        wcnt        = 0;
        if (spur) bus.nfc_done = 1'b1;
      end else if (outstanding && !stall) begin
        wcnt++;
        if (wcnt >= lat) begin
          bus.nfc_done = 1'b1;
          drove_done   = 1'b1;
          outstanding  = 1'b0;
        end
      end else if (idle_req != idle_ack) begin
        bus.nfc_done = 1'b1;
        idle_ack     = idle_req;
      end
    end
  end

  task automatic expect_cpl(input logic id, input logic [CMD_W-1:0] cmd);
    exp_t e;
    e.id  = id;
    e.cmd = cmd;
    exp_q.push_back(e);
  endtask

  task automatic push(input logic v0, input logic v1,
                      input logic [CMD_W-1:0] c0, input logic [CMD_W-1:0] c1);
    bus.req0_valid = v0;
    bus.req0_cmd   = c0;
    bus.req1_valid = v1;
    bus.req1_cmd   = c1;
    @(negedge clk);
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    stall = 1'b0;
    spur  = 1'b0;
    rst   = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain(input string tag, input int max_cyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((exp_q.size() != 0 || bus.busy) && n < max_cyc);
    check_eq(tag, (exp_q.size() == 0) && !bus.busy, 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [CMD_W-1:0] c1, z, nz, a, w0, w1, r1, x, w2, r2;
    logic [CMD_W-1:0] b[5];
    logic found;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_cmd   = '0;
    bus.req1_cmd   = '0;

    // Reset values
    do_reset();
    check_eq("rst_nfc_start", bus.nfc_start, 0);
    check_eq("rst_nfc_cmd", bus.nfc_cmd, 0);
    check_eq("rst_cpl_valid", bus.cpl_valid, 0);
    check_eq("rst_cpl_id", bus.cpl_id, 0);
    check_eq("rst_cpl_cmd", bus.cpl_cmd, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_ready0", bus.req0_ready, 1);
    check_eq("rst_ready1", bus.req1_ready, 1);

    // Stray done in IDLE must not create a completion
    idle_req++;
    repeat (3) @(negedge clk);
    check_eq("idle_done_busy", bus.busy, 0);

    // Single read command, with a stray done during ISSUE
    c1 = mk(1'b1, 18'h00100, 7'h00, 7'd16);
    spur = 1'b1;
    expect_cpl(1'b0, c1);
    push(1'b1, 1'b0, c1, '0);
    check_eq("t1_start_early", bus.nfc_start, 0);
    check_eq("t1_busy", bus.busy, 1);
    @(negedge clk);
    check_eq("t1_start", bus.nfc_start, 1);
    check_eq("t1_nfc_cmd", bus.nfc_cmd, c1);
    drain("t1_drain", 30);
    spur = 1'b0;
    check_eq("t1_nfc_cmd_held", bus.nfc_cmd, c1);
    check_eq("t1_busy_end", bus.busy, 0);

    // Both requesters push three commands in the same cycles
    do_reset();
    for (int k = 0; k < 3; k++) begin
      expect_cpl(1'b0, mk(1'b0, 18'h01000 + 18'(k), 7'h10 + 7'(k), 7'd8 + 7'(k)));
      expect_cpl(1'b1, mk(1'b1, 18'h02000 + 18'(k), 7'h20 + 7'(k), 7'd40 + 7'(k)));
    end
    for (int k = 0; k < 3; k++) begin
      push(1'b1, 1'b1, mk(1'b0, 18'h01000 + 18'(k), 7'h10 + 7'(k), 7'd8 + 7'(k)),
                       mk(1'b1, 18'h02000 + 18'(k), 7'h20 + 7'(k), 7'd40 + 7'(k)));
    end
    drain("t2_drain", 200);

    // Fill requester 1 FIFO while the NFC is stalled
    do_reset();
    stall = 1'b1;
    a = mk(1'b0, 18'h2AAAA, 7'h55, 7'd100);
    expect_cpl(1'b0, a);
    push(1'b1, 1'b0, a, '0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) b[k] = mk(1'b1, 18'h30000 + 18'(k), 7'h40 + 7'(k), 7'd1 + 7'(k));
    for (int k = 0; k < 4; k++) begin
      expect_cpl(1'b1, b[k]);
      bus.req1_valid = 1'b1;
      bus.req1_cmd   = b[k];
      @(negedge clk);
      check_eq("t3_ready_fill", bus.req1_ready, (k < 3) ? 1 : 0);
    end
    bus.req1_cmd = b[4];
    repeat (3) begin
      @(negedge clk);
      check_eq("t3_ready_full", bus.req1_ready, 0);
    end
    bus.req1_valid = 1'b0;
    stall = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      @(negedge clk);
      if (bus.nfc_start) begin
        found = 1'b1;
        check_eq("t3_ready_after_pop", bus.req1_ready, 1);
      end else begin
        check_eq("t3_ready_before_pop", bus.req1_ready, 0);
      end
    end
    check_eq("t3_next_start_seen", found, 1);
    drain("t3_drain", 100);

    // Zero-length command followed by a normal command
    do_reset();
    z  = mk(1'b1, 18'h00003, 7'h04, 7'd0);
    nz = mk(1'b0, 18'h00005, 7'h06, 7'd1);
    expect_cpl(1'b0, z);
    expect_cpl(1'b0, nz);
    push(1'b1, 1'b0, z, '0);
    check_eq("t4_cpl_early", bus.cpl_valid, 0);
    check_eq("t4_start_early", bus.nfc_start, 0);
    push(1'b1, 1'b0, nz, '0);
    check_eq("t4_cpl_valid", bus.cpl_valid, 1);
    check_eq("t4_cpl_cmd", bus.cpl_cmd, z);
    check_eq("t4_no_start", bus.nfc_start, 0);
    drain("t4_drain", 50);

    // Asynchronous reset while waiting with two queued entries
    do_reset();
    stall = 1'b1;
    a  = mk(1'b1, 18'h11111, 7'h11, 7'd9);
    w1 = mk(1'b0, 18'h22222, 7'h22, 7'd5);
    r1 = mk(1'b1, 18'h33333, 7'h33, 7'd6);
    expect_cpl(1'b1, a);
    expect_cpl(1'b0, w1);
    expect_cpl(1'b1, r1);
    push(1'b0, 1'b1, '0, a);
    @(negedge clk);
    push(1'b1, 1'b1, w1, r1);
    check_eq("t5_busy_wait", bus.busy, 1);
    check_eq("t5_ready0_pre", bus.req0_ready, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t5_nfc_start", bus.nfc_start, 0);
    check_eq("t5_nfc_cmd", bus.nfc_cmd, 0);
    check_eq("t5_cpl_valid", bus.cpl_valid, 0);
    check_eq("t5_cpl_id", bus.cpl_id, 0);
    check_eq("t5_cpl_cmd", bus.cpl_cmd, 0);
    check_eq("t5_busy", bus.busy, 0);
    check_eq("t5_ready0", bus.req0_ready, 1);
    check_eq("t5_ready1", bus.req1_ready, 1);
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    stall = 1'b0;
    repeat (20) begin
      @(negedge clk);
      check_eq("t5_post_rst_start", bus.nfc_start, 0);
    end
    check_eq("t5_post_rst_busy", bus.busy, 0);

    // Write head vs read head with rr_last = 0
    do_reset();
    stall = 1'b1;
    w0 = mk(1'b0, 18'h00A00, 7'h0A, 7'd3);
    w1 = mk(1'b0, 18'h00B00, 7'h0B, 7'd4);
    r1 = mk(1'b1, 18'h00C00, 7'h0C, 7'd5);
    expect_cpl(1'b0, w0);
    expect_cpl(1'b1, r1);
    expect_cpl(1'b0, w1);
    push(1'b1, 1'b0, w0, '0);
    @(negedge clk);
    push(1'b1, 1'b1, w1, r1);
    stall = 1'b0;
    drain("t6a_drain", 100);

    // Same contest with rr_last = 1
    do_reset();
    stall = 1'b1;
    x  = mk(1'b1, 18'h00D00, 7'h0D, 7'd6);
    w2 = mk(1'b0, 18'h00E00, 7'h0E, 7'd7);
    r2 = mk(1'b1, 18'h00F00, 7'h0F, 7'd8);
    expect_cpl(1'b1, x);
`ifdef NFC_SCHED_RDPRIO_EN
    expect_cpl(1'b1, r2);
    expect_cpl(1'b0, w2);
`else
    expect_cpl(1'b0, w2);
    expect_cpl(1'b1, r2);
`endif
    push(1'b0, 1'b1, '0, x);
    @(negedge clk);
    push(1'b1, 1'b1, w2, r2);
    stall = 1'b0;
    drain("t6b_drain", 100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
